// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce filter slice.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } deb_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer; flops reset asynchronously to RST_VAL.
module sync_2ff
    import debounce_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic aclk,
    input  logic arstn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            stages <= {SYNC_STAGES{RST_VAL}};
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Glitch filter with rise/fall pulse outputs for the ffd register stage.
// Optional DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer in front of the FSM.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int   CNT_W         = 8,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RST_LEVEL     = 1'b0
) (
    input  logic aclk,
    input  logic arstn,
    input  logic en,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > (2**CNT_W) - 1) begin : g_bad_stable_cycles
        $error("debounce_filter: STABLE_CYCLES out of range 1..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(STABLE_CYCLES - 1);
    localparam deb_state_t       RST_STATE = (RST_LEVEL == 1'b0) ? STABLE_LO : STABLE_HI;

    logic             sample;
    deb_state_t       state;
    logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff #(.RST_VAL(RST_LEVEL)) u_sync (
        .aclk  (aclk),
        .arstn (arstn),
        .d     (d),
        .q     (sample)
    );
`else
    assign sample = d;
`endif

    // q always matches the level of the current STABLE state, so q alone picks the branch targets.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state <= RST_STATE;
            cnt   <= '0;
            q     <= RST_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                case (state)
                    STABLE_LO, STABLE_HI: begin
                        if (sample == q) begin
                            cnt <= '0;
                        end else if (STABLE_CYCLES == 1) begin
                            q     <= ~q;
                            rise  <= ~q;
                            fall  <= q;
                            state <= q ? STABLE_LO : STABLE_HI;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            state <= q ? CHK_LO : CHK_HI;
                            cnt   <= CNT_W'(1);
                            busy  <= 1'b1;
                        end
                    end
                    CHK_HI, CHK_LO: begin
                        if (sample == q) begin
                            state <= q ? STABLE_HI : STABLE_LO;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else if (cnt == LAST_CNT) begin
                            q     <= ~q;
                            rise  <= ~q;
                            fall  <= q;
                            state <= q ? STABLE_LO : STABLE_HI;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= RST_STATE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
